// File: rtl/cic_integrator.sv
// CIC integrator stage: wrapping two's-complement accumulator with a valid flag.
// Ports: clk, rst (sync, active-high), in/in_valid sample in, out/out_valid/out_ready result out.
module cic_integrator #(
  parameter int WordLengthBits = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [WordLengthBits-1:0] in,
  input  logic                             in_valid,
  output logic signed [WordLengthBits-1:0] out,
  output logic                             out_valid,
  input  logic                             out_ready
);

  logic signed [WordLengthBits-1:0] r_acc;
  logic                             r_vld;
  logic signed [WordLengthBits-1:0] w_sum;

  // Same-width add: overflow wraps modulo 2^W, which CIC relies on.
  assign w_sum = r_acc + in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (in_valid) begin
      r_acc <= w_sum;
    end
  end

  // A new sample always wins over a consume in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (in_valid) begin
      r_vld <= 1'b1;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign out       = r_acc;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_cic_integrator.sv
// Bench for cic_integrator: directed phases, literal pins and random traffic.
// A behavioural running-sum model is compared against the DUT every cycle.
module tb_cic_integrator;
  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic                out_ready;
  logic signed [W-1:0] in;
  logic signed [W-1:0] out;
  logic                out_valid;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  int m_sum;
  bit m_vld;

  cic_integrator #(.WordLengthBits(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int wrap(int v);
    int m;
    m = v % (1 << W);
    if (m < 0) m += (1 << W);
    return m;
  endfunction

  // Model: running integer sum reduced modulo 2^W; valid per handshake rules.
  always @(posedge clk) begin
    if (rst) begin
      m_sum = 0;
      m_vld = 1'b0;
      run   = 1'b1;
    end else begin
      if (in_valid) m_sum = wrap(m_sum + int'(in));
      if (in_valid) m_vld = 1'b1;
      else if (out_ready) m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_out", int'(unsigned'(out)), m_sum);
      chk("model_valid", int'(out_valid), int'(m_vld));
    end
  end

  task automatic drive(bit r, bit v, int i, bit rd);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in        = W'(i);
    out_ready = rd;
  endtask

  task automatic step(bit v, int i, bit rd);
    drive(1'b0, v, i, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(string n, int exp_out, bit exp_vld);
    chk({n, "_out"}, int'(unsigned'(out)), exp_out);
    chk({n, "_vld"}, int'(out_valid), int'(exp_vld));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b0;

    drive(1'b1, 1'b1, 'hAAA, 1'b0);
    repeat (1000) @(negedge clk);
    pin("held_reset", 0, 1'b0);

    drive(1'b0, 1'b1, 0, 1'b0);
    repeat (1000) @(negedge clk);
    pin("zero_input", 0, 1'b1);

    drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 'hAAA, 1'b1);
    repeat (1000) @(negedge clk);
    pin("gate_idle", 0, 1'b0);
    drive(1'b0, 1'b1, 0, 1'b1);
    repeat (1000) @(negedge clk);
    pin("gate_on", 0, 1'b1);
    drive(1'b0, 1'b0, 'hAAA, 1'b1);
    repeat (1000) @(negedge clk);
    pin("gate_off", 0, 1'b0);

    drive(1'b0, 1'b0, 0, 1'b0);
    repeat (100) @(negedge clk);
    pin("hs_idle", 0, 1'b0);
    drive(1'b0, 1'b1, 5, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    repeat (120) @(negedge clk);
    pin("hs_held", 5, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);
    repeat (100) @(negedge clk);
    pin("hs_cleared", 5, 1'b0);

    drive(1'b1, 1'b0, 0, 1'b1);
    @(posedge clk); #1;
    pin("int_start", 0, 1'b0);
    step(1'b1, 3, 1'b1);  pin("int3a", 3, 1'b1);
    step(1'b1, 3, 1'b1);  pin("int3b", 6, 1'b1);
    step(1'b1, 3, 1'b1);  pin("int3c", 9, 1'b1);
    step(1'b1, -4, 1'b1); pin("intm4a", 5, 1'b1);
    step(1'b1, -4, 1'b1); pin("intm4b", 1, 1'b1);
    step(1'b1, -4, 1'b1); pin("intm4c", 'hFFD, 1'b1);

    step(1'b1, 2047, 1'b1); pin("pre_wrap_a", 2044, 1'b1);
    step(1'b1, 3, 1'b1);    pin("pre_wrap_b", 2047, 1'b1);
    step(1'b1, 1, 1'b1);    pin("wrap_up", 'h800, 1'b1);
    step(1'b1, -1, 1'b1);   pin("wrap_down", 'h7FF, 1'b1);
    step(1'b0, 0, 1'b1);    pin("drain", 'h7FF, 1'b0);

    for (int k = 0; k < 4000; k++) begin
      drive(($urandom % 97) == 0, $urandom % 2, int'($urandom % 4096),
            ($urandom % 3) == 0);
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
